// File: rtl/alu_issue_ctrl_pkg.sv
// Shared constants for the ALU issue/writeback sequencer: ALU opcodes, RV32I
// opcode/funct3 encodings, FSM state type and the funct3-to-ALU-op mapping.
package alu_issue_ctrl_pkg;

    localparam logic [3:0] ALU_NONE             = 4'd0;
    localparam logic [3:0] ALU_ADD              = 4'd1;
    localparam logic [3:0] ALU_SUB              = 4'd2;
    localparam logic [3:0] ALU_SHIFTL           = 4'd3;
    localparam logic [3:0] ALU_LESS_THAN_SIGNED = 4'd4;
    localparam logic [3:0] ALU_LESS_THAN        = 4'd5;
    localparam logic [3:0] ALU_XOR              = 4'd6;
    localparam logic [3:0] ALU_SHIFTR           = 4'd7;
    localparam logic [3:0] ALU_SHIFTR_ARITH     = 4'd8;
    localparam logic [3:0] ALU_OR               = 4'd9;
    localparam logic [3:0] ALU_AND              = 4'd10;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    // alt selects SUB for funct3=000 and arithmetic shift for funct3=101.
    function automatic logic [3:0] alu_op_from_f3(input logic [2:0] f3, input logic alt);
        logic [3:0] op;
        case (f3)
            F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  op = ALU_SHIFTL;
            F3_SLT:  op = ALU_LESS_THAN_SIGNED;
            F3_SLTU: op = ALU_LESS_THAN;
            F3_XOR:  op = ALU_XOR;
            F3_SR:   op = alt ? ALU_SHIFTR_ARITH : ALU_SHIFTR;
            F3_OR:   op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/rv32_imm_gen.sv
// Combinational RV32I immediate extraction: sign-extended I and B immediates
// and the upper-aligned U immediate.
module rv32_imm_gen (
    input  logic [31:7] instr,
    output logic [31:0] imm_i,
    output logic [31:0] imm_u,
    output logic [31:0] imm_b
);

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback sequencer driving a combinational ALU for RV32I ops.
// Optional operand forwarding from the last writeback: define ALU_ISSUE_FWD_EN.
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int ALU_OP_W = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                instr_valid_i,
    output logic                instr_ready_o,
    input  logic [31:0]         instr_i,
    input  logic [XLEN-1:0]     pc_i,
    input  logic [XLEN-1:0]     rs1_data_i,
    input  logic [XLEN-1:0]     rs2_data_i,
    output logic [ALU_OP_W-1:0] alu_op_o,
    output logic [XLEN-1:0]     alu_a_o,
    output logic [XLEN-1:0]     alu_b_o,
    input  logic [XLEN-1:0]     alu_out_i,
    output logic                wb_valid_o,
    input  logic                wb_ready_i,
    output logic                wb_we_o,
    output logic [4:0]          wb_rd_o,
    output logic [XLEN-1:0]     wb_data_o,
    output logic                wb_br_taken_o,
    output logic [XLEN-1:0]     wb_br_target_o,
    output logic                wb_illegal_o
);

    state_t state, state_nxt;
    logic   accept;
    logic   wb_hs;

    logic [XLEN-1:0] imm_i, imm_u, imm_b;
    logic [XLEN-1:0] rs1_val, rs2_val;

    logic [ALU_OP_W-1:0] dec_op;
    logic [XLEN-1:0]     dec_a, dec_b;
    logic                dec_illegal, dec_branch, dec_lui;

    logic [4:0]      rd_p1;
    logic [2:0]      f3_p1;
    logic            branch_p1, illegal_p1, lui_p1;
    logic [XLEN-1:0] target_p1;
    logic            br_taken;

    rv32_imm_gen u_imm_gen (
        .instr (instr_i[31:7]),
        .imm_i (imm_i),
        .imm_u (imm_u),
        .imm_b (imm_b)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        instr_ready_o = 1'b0;
        case (state)
            ST_IDLE: begin
                instr_ready_o = 1'b1;
                if (instr_valid_i) state_nxt = ST_EXEC;
            end
            ST_EXEC: state_nxt = ST_WB;
            ST_WB: begin
                instr_ready_o = wb_ready_i;
                if (wb_ready_i) state_nxt = instr_valid_i ? ST_EXEC : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign accept = instr_valid_i && instr_ready_o;
    assign wb_hs  = wb_valid_o && wb_ready_i;

`ifdef ALU_ISSUE_FWD_EN
    logic [4:0]      fwd_rd, last_rd;
    logic [XLEN-1:0] fwd_data, last_data;

    // A beat handed off in the accept cycle is newer than the stored one.
    always_comb begin
        last_rd   = fwd_rd;
        last_data = fwd_data;
        if (wb_hs && wb_we_o) begin
            last_rd   = wb_rd_o;
            last_data = wb_data_o;
        end
    end

    assign rs1_val = (last_rd != 5'd0 && instr_i[19:15] == last_rd) ? last_data : rs1_data_i;
    assign rs2_val = (last_rd != 5'd0 && instr_i[24:20] == last_rd) ? last_data : rs2_data_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fwd_rd <= 5'd0;
        end else if (wb_hs && wb_we_o) begin
            fwd_rd   <= wb_rd_o;
            fwd_data <= wb_data_o;
        end
    end
`else
    assign rs1_val = rs1_data_i;
    assign rs2_val = rs2_data_i;
`endif

    always_comb begin
        dec_op      = ALU_NONE;
        dec_a       = '0;
        dec_b       = '0;
        dec_illegal = 1'b0;
        dec_branch  = 1'b0;
        dec_lui     = 1'b0;
        case (instr_i[6:0])
            OPC_OP: begin
                dec_op = alu_op_from_f3(instr_i[14:12], instr_i[30]);
                dec_a  = rs1_val;
                dec_b  = rs2_val;
            end
            OPC_OP_IMM: begin
                // Bit 30 is part of the immediate for ADDI, so only shifts use it.
                dec_op = alu_op_from_f3(instr_i[14:12], (instr_i[14:12] == F3_SR) && instr_i[30]);
                dec_a  = rs1_val;
                dec_b  = imm_i;
                if (instr_i[14:12] == F3_SLL || instr_i[14:12] == F3_SR)
                    dec_b = {{(XLEN-5){1'b0}}, instr_i[24:20]};
            end
            OPC_LUI: begin
                dec_a   = imm_u;
                dec_lui = 1'b1;
            end
            OPC_AUIPC: begin
                dec_op = ALU_ADD;
                dec_a  = pc_i;
                dec_b  = imm_u;
            end
            OPC_BRANCH: begin
                dec_a      = rs1_val;
                dec_b      = rs2_val;
                dec_branch = 1'b1;
                case (instr_i[14:12])
                    F3_BEQ, F3_BNE:   dec_op = ALU_SUB;
                    F3_BLT, F3_BGE:   dec_op = ALU_LESS_THAN_SIGNED;
                    F3_BLTU, F3_BGEU: dec_op = ALU_LESS_THAN;
                    default: begin
                        dec_branch  = 1'b0;
                        dec_illegal = 1'b1;
                    end
                endcase
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    // accept -> p1: per-instruction control captured with the ALU operands
    always_ff @(posedge clk_i) begin
        if (accept) begin
            rd_p1      <= instr_i[11:7];
            f3_p1      <= instr_i[14:12];
            branch_p1  <= dec_branch;
            illegal_p1 <= dec_illegal;
            lui_p1     <= dec_lui;
            target_p1  <= pc_i + imm_b;
        end
    end

    always_comb begin
        case (f3_p1)
            F3_BEQ:          br_taken = (alu_out_i == '0);
            F3_BNE:          br_taken = (alu_out_i != '0);
            F3_BLT, F3_BLTU: br_taken = alu_out_i[0];
            default:         br_taken = !alu_out_i[0];
        endcase
    end

    // p1 -> writeback: ALU result sampled in EXEC, held until the consumer takes it
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            alu_op_o       <= ALU_NONE;
            alu_a_o        <= '0;
            alu_b_o        <= '0;
            wb_valid_o     <= 1'b0;
            wb_we_o        <= 1'b0;
            wb_rd_o        <= 5'd0;
            wb_data_o      <= '0;
            wb_br_taken_o  <= 1'b0;
            wb_br_target_o <= '0;
            wb_illegal_o   <= 1'b0;
        end else begin
            if (accept) begin
                alu_op_o <= dec_op;
                alu_a_o  <= dec_a;
                alu_b_o  <= dec_b;
            end
            if (state == ST_EXEC) begin
                wb_valid_o     <= 1'b1;
                wb_we_o        <= !illegal_p1 && !branch_p1 && (rd_p1 != 5'd0);
                wb_rd_o        <= rd_p1;
                wb_data_o      <= lui_p1 ? alu_a_o : alu_out_i;
                wb_br_taken_o  <= branch_p1 && br_taken;
                wb_br_target_o <= target_p1;
                wb_illegal_o   <= illegal_p1;
            end else if (wb_hs) begin
                wb_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU on the op/a/b/out interface.
module tb_alu_issue_ctrl;
    import alu_issue_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [31:0] instr = 32'h0;
    logic [31:0] pc = 32'h0;
    logic [31:0] rs1_data = 32'h0;
    logic [31:0] rs2_data = 32'h0;
    logic [3:0]  alu_op;
    logic [31:0] alu_a, alu_b, alu_out;
    logic        wb_valid;
    logic        wb_ready = 1'b0;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_br_taken;
    logic [31:0] wb_br_target;
    logic        wb_illegal;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] I_ADD   = 32'h002081B3; // add  x3,x1,x2
    localparam logic [31:0] I_SRAI  = 32'h4042D213; // srai x4,x5,4
    localparam logic [31:0] I_BNE   = 32'h00209463; // bne  x1,x2,+8
    localparam logic [31:0] I_ADDI  = 32'h00900093; // addi x1,x0,9
    localparam logic [31:0] I_ADD2  = 32'h00108133; // add  x2,x1,x1
    localparam logic [31:0] I_ILLEG = 32'h0000007F;

    always #5 clk = ~clk;

    alu_issue_ctrl dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .instr_valid_i  (instr_valid),
        .instr_ready_o  (instr_ready),
        .instr_i        (instr),
        .pc_i           (pc),
        .rs1_data_i     (rs1_data),
        .rs2_data_i     (rs2_data),
        .alu_op_o       (alu_op),
        .alu_a_o        (alu_a),
        .alu_b_o        (alu_b),
        .alu_out_i      (alu_out),
        .wb_valid_o     (wb_valid),
        .wb_ready_i     (wb_ready),
        .wb_we_o        (wb_we),
        .wb_rd_o        (wb_rd),
        .wb_data_o      (wb_data),
        .wb_br_taken_o  (wb_br_taken),
        .wb_br_target_o (wb_br_target),
        .wb_illegal_o   (wb_illegal)
    );

    always_comb begin
        alu_out = alu_a;
        case (alu_op)
            ALU_ADD:              alu_out = alu_a + alu_b;
            ALU_SUB:              alu_out = alu_a - alu_b;
            ALU_SHIFTL:           alu_out = alu_a << alu_b[4:0];
            ALU_LESS_THAN_SIGNED: alu_out = {31'b0, $signed(alu_a) < $signed(alu_b)};
            ALU_LESS_THAN:        alu_out = {31'b0, alu_a < alu_b};
            ALU_XOR:              alu_out = alu_a ^ alu_b;
            ALU_SHIFTR:           alu_out = alu_a >> alu_b[4:0];
            ALU_SHIFTR_ARITH:     alu_out = $unsigned($signed(alu_a) >>> alu_b[4:0]);
            ALU_OR:               alu_out = alu_a | alu_b;
            ALU_AND:              alu_out = alu_a & alu_b;
            default:              alu_out = alu_a;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", instr_ready); end
        checks++; if (alu_op !== ALU_NONE) begin errors++; $display("FAIL rst_op got %h exp %h", alu_op, ALU_NONE); end
        checks++; if (alu_a !== 32'h0 || alu_b !== 32'h0) begin errors++; $display("FAIL rst_ab got %h/%h exp 0/0", alu_a, alu_b); end
        checks++; if (wb_valid !== 1'b0 || wb_we !== 1'b0 || wb_illegal !== 1'b0 || wb_br_taken !== 1'b0) begin
            errors++; $display("FAIL rst_wbflags got v%b we%b il%b tk%b exp 0000", wb_valid, wb_we, wb_illegal, wb_br_taken); end
        checks++; if (wb_data !== 32'h0 || wb_rd !== 5'd0 || wb_br_target !== 32'h0) begin
            errors++; $display("FAIL rst_wbdata got %h/%0d/%h exp 0/0/0", wb_data, wb_rd, wb_br_target); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_add();
        instr = I_ADD; rs1_data = 32'd5; rs2_data = 32'd7; instr_valid = 1'b1; wb_ready = 1'b0;
        tick();
        instr_valid = 1'b0;
        checks++; if (alu_op !== ALU_ADD) begin errors++; $display("FAIL add_op got %h exp %h", alu_op, ALU_ADD); end
        checks++; if (alu_a !== 32'd5 || alu_b !== 32'd7) begin errors++; $display("FAIL add_ab got %h/%h exp 5/7", alu_a, alu_b); end
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL add_early_valid got %b exp 0", wb_valid); end
        tick();
        checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL add_valid got %b exp 1", wb_valid); end
        checks++; if (wb_rd !== 5'd3 || wb_data !== 32'd12 || wb_we !== 1'b1) begin
            errors++; $display("FAIL add_wb got rd%0d d%h we%b exp rd3 d0000000c we1", wb_rd, wb_data, wb_we); end
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL add_drain got %b exp 0", wb_valid); end
    endtask

    task automatic test_srai();
        instr = I_SRAI; rs1_data = 32'h8000_0000; rs2_data = 32'h0; instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        checks++; if (alu_op !== ALU_SHIFTR_ARITH || alu_b !== 32'd4) begin
            errors++; $display("FAIL srai_opb got %h/%h exp %h/4", alu_op, alu_b, ALU_SHIFTR_ARITH); end
        tick();
        checks++; if (wb_data !== 32'hF800_0000 || wb_rd !== 5'd4 || wb_we !== 1'b1) begin
            errors++; $display("FAIL srai_wb got d%h rd%0d we%b exp f8000000 4 1", wb_data, wb_rd, wb_we); end
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
    endtask

    task automatic test_branch();
        instr = I_BNE; pc = 32'h100; rs1_data = 32'd1; rs2_data = 32'd2; instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        checks++; if (alu_op !== ALU_SUB) begin errors++; $display("FAIL bne_op got %h exp %h", alu_op, ALU_SUB); end
        tick();
        checks++; if (wb_br_taken !== 1'b1 || wb_br_target !== 32'h108 || wb_we !== 1'b0) begin
            errors++; $display("FAIL bne_taken got tk%b tgt%h we%b exp 1 108 0", wb_br_taken, wb_br_target, wb_we); end
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
        rs1_data = 32'd3; rs2_data = 32'd3; instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick();
        checks++; if (wb_valid !== 1'b1 || wb_br_taken !== 1'b0 || wb_we !== 1'b0) begin
            errors++; $display("FAIL bne_equal got v%b tk%b we%b exp 1 0 0", wb_valid, wb_br_taken, wb_we); end
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
        pc = 32'h0;
    endtask

    task automatic test_backpressure();
        instr = I_ADD; rs1_data = 32'd5; rs2_data = 32'd7; instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick();
        instr_valid = 1'b1; rs1_data = 32'd10; rs2_data = 32'd20;
        for (int i = 0; i < 3; i++) begin
            checks++; if (wb_valid !== 1'b1 || wb_data !== 32'd12 || wb_rd !== 5'd3 || alu_a !== 32'd5) begin
                errors++; $display("FAIL bp_hold%0d got v%b d%h rd%0d a%h exp 1 c 3 5", i, wb_valid, wb_data, wb_rd, alu_a); end
            checks++; if (instr_ready !== 1'b0) begin errors++; $display("FAIL bp_ready%0d got %b exp 0", i, instr_ready); end
            tick();
        end
        wb_ready = 1'b1;
        #1;
        checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_release got %b exp 1", instr_ready); end
        tick();
        instr_valid = 1'b0; wb_ready = 1'b0;
        checks++; if (wb_valid !== 1'b0 || alu_a !== 32'd10 || alu_b !== 32'd20) begin
            errors++; $display("FAIL bp_same_cycle got v%b a%h b%h exp 0 a 14", wb_valid, alu_a, alu_b); end
        tick();
        checks++; if (wb_valid !== 1'b1 || wb_data !== 32'd30) begin
            errors++; $display("FAIL bp_second_wb got v%b d%h exp 1 1e", wb_valid, wb_data); end
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
    endtask

    task automatic test_illegal();
        instr = I_ILLEG; instr_valid = 1'b1; rs1_data = 32'h55; rs2_data = 32'h66;
        tick();
        instr_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (wb_valid !== 1'b0 || alu_op !== ALU_NONE || alu_a !== 32'h0 || wb_illegal !== 1'b0) begin
            errors++; $display("FAIL ill_rst got v%b op%h a%h il%b exp 0 0 0 0", wb_valid, alu_op, alu_a, wb_illegal); end
        tick();
        checks++; if (wb_valid !== 1'b0 || instr_ready !== 1'b1) begin
            errors++; $display("FAIL ill_rst_after got v%b rdy%b exp 0 1", wb_valid, instr_ready); end
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick();
        checks++; if (wb_valid !== 1'b1 || wb_illegal !== 1'b1 || wb_we !== 1'b0 || alu_op !== ALU_NONE) begin
            errors++; $display("FAIL ill_beat got v%b il%b we%b op%h exp 1 1 0 0", wb_valid, wb_illegal, wb_we, alu_op); end
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_ab;
        logic [31:0] exp_sum;
`ifdef ALU_ISSUE_FWD_EN
        exp_ab = 32'd9;
`else
        exp_ab = 32'd0;
`endif
        exp_sum = exp_ab + exp_ab;
        instr = I_ADDI; rs1_data = 32'h0; rs2_data = 32'h0; instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick();
        checks++; if (wb_data !== 32'd9 || wb_rd !== 5'd1) begin
            errors++; $display("FAIL b2b_addi got d%h rd%0d exp 9 1", wb_data, wb_rd); end
        instr = I_ADD2; instr_valid = 1'b1; wb_ready = 1'b1;
        tick();
        instr_valid = 1'b0; wb_ready = 1'b0;
        checks++; if (alu_a !== exp_ab || alu_b !== exp_ab) begin
            errors++; $display("FAIL b2b_fwd got %h/%h exp %h/%h", alu_a, alu_b, exp_ab, exp_ab); end
        tick();
        checks++; if (wb_data !== exp_sum || wb_rd !== 5'd2) begin
            errors++; $display("FAIL b2b_wb got d%h rd%0d exp %h 2", wb_data, wb_rd, exp_sum); end
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_add();
        test_srai();
        test_branch();
        test_backpressure();
        test_illegal();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
